// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback
// sources, plus a 32-entry pending-write scoreboard. Define WB_OUTREG_EN to register the write port.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic [31:0]          busy,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [31:0]     r_busy;

  logic [4:0]      w_addr_a [NREQ];
  logic [XLEN-1:0] w_data_a [NREQ];

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_hs;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_idx;

  logic            w_wen;
  logic [4:0]      w_waddr;
  logic [XLEN-1:0] w_wdata;

  logic            w_clr_en;
  logic [4:0]      w_clr_addr;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_busy_nxt;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g] = req_addr[5*g +: 5];
    assign w_data_a[g] = req_data[XLEN*g +: XLEN];
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] gidx);
    if (gidx == PW'(NREQ - 1)) return '0;
    return gidx + 1'b1;
  endfunction

  // Arbitration: walk upward from the pointer, first valid requester wins.
  // Reset gates the grant so no handshake is visible while rst is low.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_hs    = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      w_idx = w_sum[PW-1:0];
      if (!w_hs && req_valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gidx         = w_idx;
        w_hs           = 1'b1;
      end
    end
    if (!rst) begin
      w_grant = '0;
      w_hs    = 1'b0;
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= next_ptr(w_gidx);
    end
  end

  // x0 writebacks are accepted but never assert the write enable.
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (w_hs) begin
      w_waddr = w_addr_a[w_gidx];
      w_wdata = w_data_a[w_gidx];
      w_wen   = (w_addr_a[w_gidx] != 5'd0);
    end
  end

`ifdef WB_OUTREG_EN
  logic            r_rf_wen;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_wen   <= w_wen;
      r_rf_waddr <= w_waddr;
      r_rf_wdata <= w_wdata;
    end
  end

  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  // Clear follows the registered write so busy drops only once the data is visible.
  assign w_clr_en   = r_rf_wen;
  assign w_clr_addr = r_rf_waddr;
`else
  assign rf_wen     = w_wen;
  assign rf_waddr   = w_waddr;
  assign rf_wdata   = w_wdata;
  assign w_clr_en   = w_wen;
  assign w_clr_addr = w_waddr;
`endif

  // Set is applied after clear so a newly issued writer of the same register keeps it busy.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid) w_set_mask[issue_rd] = 1'b1;
    if (w_clr_en)    w_clr_mask[w_clr_addr] = 1'b1;
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

endmodule
